// File: rtl/seg_pkg.sv
// Shared constants, scan state encoding and digit-slice helper for the
// multiplexed eight-digit seven-segment scan controller.
package seg_pkg;

    localparam int         NDIG    = 8;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] SEL_OFF = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_e;

    // Pull digit i's 7-bit pattern out of a packed 56-bit segment bus.
    function automatic logic [6:0] digit_slice(input logic [55:0] bus, input logic [2:0] i);
        return bus[7*i +: 7];
    endfunction

endpackage

// File: rtl/seg_next_digit.sv
// Combinational search for the next enabled digit strictly after the current
// index, wrapping modulo 8. The wrap flag marks the end of a scan frame: the
// found index is at or below the current one. With no digit enabled the index
// is returned unchanged and no wrap is reported.
module seg_next_digit
    import seg_pkg::*;
(
    input  logic [NDIG-1:0] i_digit_en,
    input  logic [2:0]      i_idx,
    output logic [2:0]      o_next_idx,
    output logic            o_wrap
);

    logic [2:0] w_cand;
    logic       w_found;

    // Scan idx+1 .. idx+8; the eighth candidate is idx itself (single enabled digit).
    always_comb begin
        o_next_idx = i_idx;
        w_found    = 1'b0;
        w_cand     = i_idx;
        for (int k = 1; k <= NDIG; k++) begin
            w_cand = i_idx + 3'(k);
            if (!w_found && i_digit_en[w_cand]) begin
                o_next_idx = w_cand;
                w_found    = 1'b1;
            end
        end
        o_wrap = w_found && (o_next_idx <= i_idx);
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan scheduler for the 8-digit multiplexed seven-segment display.
// Each digit slot lasts DIV cycles: BLANK cycles with all outputs off, then
// DIV-BLANK cycles driving the latched pattern of one digit. Disabled digits
// are skipped. A timed message overlay replaces the game patterns for
// HOLD_FRAMES whole frames, switching only on frame boundaries.
// Parameter constraints: DIV >= 2, 1 <= BLANK < DIV, HOLD_FRAMES >= 1.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIV         = 100000,
    parameter int BLANK       = 2000,
    parameter int HOLD_FRAMES = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  digit_en,
    input  logic [55:0] game_seg,
    input  logic [55:0] msg_seg,
    input  logic        msg_req,
    output logic        msg_busy,
    output logic [6:0]  segval,
    output logic [7:0]  select,
    output logic        frame_tick
);

    localparam int               CNT_W      = $clog2(DIV);
    localparam int               FRM_W      = $clog2(HOLD_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(HOLD_FRAMES - 1);

    // Scan FSM state and slot position
    scan_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;

    scan_state_e      w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_idx_nxt;

    // Registered pin drive
    logic [7:0]       r_select;
    logic [6:0]       r_segval;
    logic             r_frame_tick;

    logic [7:0]       w_select_nxt;
    logic [6:0]       w_segval_nxt;
    logic             w_tick_nxt;

    // Overlay arbitration
    logic             r_pending;
    logic             r_overlay;
    logic [FRM_W-1:0] r_frm_cnt;
    logic             r_busy;

    logic             w_pending_nxt;
    logic             w_overlay_nxt;
    logic [FRM_W-1:0] w_frm_cnt_nxt;
    logic             w_busy_nxt;

    // Next-digit search
    logic [2:0]       w_search_idx;
    logic [2:0]       w_next_idx;
    logic             w_wrap;
    logic [55:0]      w_src_bus;

    // From IDLE, searching after digit 7 yields the lowest enabled digit.
    assign w_search_idx = (r_state == ST_IDLE) ? 3'(NDIG - 1) : r_idx;
    assign w_src_bus    = r_overlay ? msg_seg : game_seg;

    seg_next_digit u_next (
        .i_digit_en (digit_en),
        .i_idx      (w_search_idx),
        .o_next_idx (w_next_idx),
        .o_wrap     (w_wrap)
    );

    // State register: FSM state, slot counter and current digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state logic; digit_en is only consulted at slot boundaries.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (digit_en != '0) begin
                    w_state_nxt = ST_BLANK;
                    w_idx_nxt   = w_next_idx;
                end
            end
            ST_BLANK: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == BLANK_LAST) begin
                    w_state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
                    if (digit_en == '0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_BLANK;
                        w_idx_nxt   = w_next_idx;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic: latch the pattern on BLANK->DRIVE, hold it through DRIVE,
    // blank otherwise; flag the last cycle of a slot whose successor wraps.
    always_comb begin
        w_select_nxt = SEL_OFF;
        w_segval_nxt = SEG_OFF;
        if (r_state == ST_BLANK && r_cnt == BLANK_LAST) begin
            w_select_nxt = ~(8'b1 << r_idx);
            w_segval_nxt = digit_slice(w_src_bus, r_idx);
        end else if (r_state == ST_DRIVE && r_cnt != CNT_LAST) begin
            w_select_nxt = r_select;
            w_segval_nxt = r_segval;
        end
        w_tick_nxt = (w_state_nxt == ST_DRIVE) && (w_cnt_nxt == CNT_LAST) && w_wrap;
    end

    // Output registers, updated on the same edge as the state transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_select     <= SEL_OFF;
            r_segval     <= SEG_OFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_select     <= w_select_nxt;
            r_segval     <= w_segval_nxt;
            r_frame_tick <= w_tick_nxt;
        end
    end

    // Overlay arbitration: requests are accepted only when not busy, and the
    // source changes only on the edge that ends a frame (r_frame_tick high).
    always_comb begin
        w_pending_nxt = r_pending | (msg_req & ~r_busy);
        w_overlay_nxt = r_overlay;
        w_frm_cnt_nxt = r_frm_cnt;
        if (r_frame_tick) begin
            if (r_overlay) begin
                if (r_frm_cnt == FRM_LAST) begin
                    w_overlay_nxt = 1'b0;
                    w_frm_cnt_nxt = '0;
                end else begin
                    w_frm_cnt_nxt = r_frm_cnt + FRM_W'(1);
                end
            end else if (w_pending_nxt) begin
                w_overlay_nxt = 1'b1;
                w_pending_nxt = 1'b0;
                w_frm_cnt_nxt = '0;
            end
        end
        w_busy_nxt = w_pending_nxt | w_overlay_nxt;
    end

    // Arbitration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_overlay <= 1'b0;
            r_frm_cnt <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            r_overlay <= w_overlay_nxt;
            r_frm_cnt <= w_frm_cnt_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign select     = r_select;
    assign segval     = r_segval;
    assign frame_tick = r_frame_tick;
    assign msg_busy   = r_busy;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with DIV=4, BLANK=1, HOLD_FRAMES=2.
// Each scenario pushes the expected per-cycle {select, segval, frame_tick,
// msg_busy} into a scoreboard queue, then steps the clock and pops/compares.
module tb_seg_scan_ctrl;

    localparam int DIV  = 4;
    localparam int BLNK = 1;
    localparam int HOLD = 2;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic [7:0]  digit_en = 8'h00;
    logic [55:0] game_seg = '0;
    logic [55:0] msg_seg  = '0;
    logic        msg_req  = 1'b0;
    logic        msg_busy;
    logic [6:0]  segval;
    logic [7:0]  select;
    logic        frame_tick;

    int          checks   = 0;
    int          failures = 0;

    // {select[7:0], segval[6:0], frame_tick, msg_busy}
    logic [16:0] sb[$];
    logic [16:0] e;
    logic [6:0]  gpat[8];
    logic [6:0]  mpat[8];

    seg_scan_ctrl #(
        .DIV         (DIV),
        .BLANK       (BLNK),
        .HOLD_FRAMES (HOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digit_en   (digit_en),
        .game_seg   (game_seg),
        .msg_seg    (msg_seg),
        .msg_req    (msg_req),
        .msg_busy   (msg_busy),
        .segval     (segval),
        .select     (select),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic load_patterns();
        for (int i = 0; i < 8; i++) begin
            game_seg[7*i +: 7] = gpat[i];
            msg_seg[7*i +: 7]  = mpat[i];
        end
    endtask

    // One slot: a blank cycle then three cycles driving digit d; bm gives busy per cycle.
    task automatic push_slot(input int d, input logic [6:0] s, input logic tick, input logic [3:0] bm);
        logic [7:0] sel;
        sel = ~(8'd1 << d);
        sb.push_back({8'hFF, 7'h7F, 1'b0, bm[0]});
        for (int k = 1; k < DIV; k++)
            sb.push_back({sel, s, (k == DIV - 1) ? tick : 1'b0, bm[k]});
    endtask

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++) sb.push_back({8'hFF, 7'h7F, 1'b0, 1'b0});
    endtask

    // Hold reset for three edges, then release with the given enables.
    task automatic do_reset(input logic [7:0] en);
        reset   = 1'b1;
        msg_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sb.delete();
        reset    = 1'b0;
        digit_en = en;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        digit_en = 8'h03;
        msg_req  = 1'b1;
        push_idle(3);
        for (int c = 0; sb.size() > 0; c++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({select, segval, frame_tick, msg_busy} !== e) begin
                failures++;
                $display("FAIL reset c=%0d got sel=%h seg=%h tick=%b busy=%b want sel=%h seg=%h tick=%b busy=%b",
                         c, select, segval, frame_tick, msg_busy, e[16:9], e[8:2], e[1], e[0]);
            end
        end
        msg_req = 1'b0;
    endtask

    task automatic test_scan_two_digits();
        do_reset(8'h03);
        push_slot(0, gpat[0], 1'b0, 4'h0);
        push_slot(1, gpat[1], 1'b1, 4'h0);
        for (int f = 0; f < 2; f++) begin
            push_slot(0, 7'h55, 1'b0, 4'h0);
            push_slot(1, gpat[1], 1'b1, 4'h0);
        end
        for (int c = 0; sb.size() > 0; c++) begin
            if (c == 2) begin
                gpat[0] = 7'h55;
                load_patterns();
            end
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({select, segval, frame_tick, msg_busy} !== e) begin
                failures++;
                $display("FAIL scan_two c=%0d got sel=%h seg=%h tick=%b busy=%b want sel=%h seg=%h tick=%b busy=%b",
                         c, select, segval, frame_tick, msg_busy, e[16:9], e[8:2], e[1], e[0]);
            end
        end
        gpat[0] = 7'h10;
        load_patterns();
    endtask

    task automatic test_skip_digits();
        do_reset(8'h85);
        push_slot(0, gpat[0], 1'b0, 4'h0);
        push_slot(2, gpat[2], 1'b0, 4'h0);
        push_slot(7, gpat[7], 1'b1, 4'h0);
        for (int f = 0; f < 2; f++) begin
            push_slot(0, gpat[0], 1'b0, 4'h0);
            push_slot(7, gpat[7], 1'b1, 4'h0);
        end
        for (int c = 0; sb.size() > 0; c++) begin
            if (c == 13) digit_en = 8'h81;
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({select, segval, frame_tick, msg_busy} !== e) begin
                failures++;
                $display("FAIL skip c=%0d got sel=%h seg=%h tick=%b busy=%b want sel=%h seg=%h tick=%b busy=%b",
                         c, select, segval, frame_tick, msg_busy, e[16:9], e[8:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_disable();
        do_reset(8'h03);
        push_slot(0, gpat[0], 1'b0, 4'h0);
        push_slot(1, gpat[1], 1'b0, 4'h0);
        push_idle(4);
        push_slot(4, gpat[4], 1'b1, 4'h0);
        push_slot(4, gpat[4], 1'b1, 4'h0);
        for (int c = 0; sb.size() > 0; c++) begin
            if (c == 5)  digit_en = 8'h00;
            if (c == 12) digit_en = 8'h10;
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({select, segval, frame_tick, msg_busy} !== e) begin
                failures++;
                $display("FAIL disable c=%0d got sel=%h seg=%h tick=%b busy=%b want sel=%h seg=%h tick=%b busy=%b",
                         c, select, segval, frame_tick, msg_busy, e[16:9], e[8:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_overlay();
        do_reset(8'h03);
        push_slot(0, gpat[0], 1'b0, 4'b1100);
        push_slot(1, gpat[1], 1'b1, 4'hF);
        for (int f = 0; f < HOLD; f++) begin
            push_slot(0, mpat[0], 1'b0, 4'hF);
            push_slot(1, mpat[1], 1'b1, 4'hF);
        end
        push_slot(0, gpat[0], 1'b0, 4'h0);
        push_slot(1, gpat[1], 1'b1, 4'h0);
        for (int c = 0; sb.size() > 0; c++) begin
            msg_req = (c == 2);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({select, segval, frame_tick, msg_busy} !== e) begin
                failures++;
                $display("FAIL overlay c=%0d got sel=%h seg=%h tick=%b busy=%b want sel=%h seg=%h tick=%b busy=%b",
                         c, select, segval, frame_tick, msg_busy, e[16:9], e[8:2], e[1], e[0]);
            end
        end
        msg_req = 1'b0;
    endtask

    task automatic test_overlay_requests();
        do_reset(8'h03);
        push_slot(0, gpat[0], 1'b0, 4'b1100);
        push_slot(1, gpat[1], 1'b1, 4'hF);
        for (int f = 0; f < HOLD; f++) begin
            push_slot(0, mpat[0], 1'b0, 4'hF);
            push_slot(1, mpat[1], 1'b1, 4'hF);
        end
        push_slot(0, gpat[0], 1'b0, 4'h0);
        push_slot(1, gpat[1], 1'b1, 4'h0);
        for (int f = 0; f < HOLD; f++) begin
            push_slot(0, mpat[0], 1'b0, 4'hF);
            push_slot(1, mpat[1], 1'b1, 4'hF);
        end
        push_slot(0, gpat[0], 1'b0, 4'h0);
        push_slot(1, gpat[1], 1'b1, 4'h0);
        for (int c = 0; sb.size() > 0; c++) begin
            msg_req = (c == 2) || (c == 12) || (c == 20) || (c == 32);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({select, segval, frame_tick, msg_busy} !== e) begin
                failures++;
                $display("FAIL overlay_req c=%0d got sel=%h seg=%h tick=%b busy=%b want sel=%h seg=%h tick=%b busy=%b",
                         c, select, segval, frame_tick, msg_busy, e[16:9], e[8:2], e[1], e[0]);
            end
        end
        msg_req = 1'b0;
    endtask

    task automatic test_reset_during_overlay();
        do_reset(8'h03);
        push_slot(0, gpat[0], 1'b0, 4'b1100);
        push_slot(1, gpat[1], 1'b1, 4'hF);
        sb.push_back({8'hFF, 7'h7F, 1'b0, 1'b1});
        sb.push_back({8'hFE, mpat[0], 1'b0, 1'b1});
        push_idle(2);
        push_slot(0, gpat[0], 1'b0, 4'h0);
        push_slot(1, gpat[1], 1'b1, 4'h0);
        for (int c = 0; sb.size() > 0; c++) begin
            msg_req = (c == 2);
            reset   = (c == 10) || (c == 11);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({select, segval, frame_tick, msg_busy} !== e) begin
                failures++;
                $display("FAIL reset_ovl c=%0d got sel=%h seg=%h tick=%b busy=%b want sel=%h seg=%h tick=%b busy=%b",
                         c, select, segval, frame_tick, msg_busy, e[16:9], e[8:2], e[1], e[0]);
            end
        end
        msg_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            gpat[i] = 7'(16 + i);
            mpat[i] = 7'(64 + i);
        end
        load_patterns();
        test_reset();
        test_scan_two_digits();
        test_skip_digits();
        test_disable();
        test_overlay();
        test_overlay_requests();
        test_reset_during_overlay();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
